// File: rtl/usb_pkg.sv
// Shared constants and types for the USB receive path: sync bytes, type tag,
// error codes and the packet receiver state encoding.
package usb_pkg;

    localparam logic [7:0] SYNC_0   = 8'h55;
    localparam logic [7:0] SYNC_1   = 8'hAA;
    localparam logic [3:0] TYPE_TAG = 4'hA;

    typedef enum logic [1:0] {
        ERR_OK   = 2'd0,
        ERR_TMO  = 2'd1,
        ERR_LEN  = 2'd2,
        ERR_CSUM = 2'd3
    } err_t;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_HUNT,
        ST_SYNC1,
        ST_TYPE,
        ST_LENH,
        ST_LENL,
        ST_DATA,
        ST_CSUM,
        ST_DONE
    } state_t;

    // A length is usable when it is non-zero and fits the payload buffer.
    function automatic logic len_ok(input logic [15:0] l, input int unsigned max_len);
        return (l != 16'd0) && (32'(l) <= max_len);
    endfunction

endpackage

// File: rtl/usb_rx_pkt_if.sv
// Byte-stream, fs/fd handshake, result and RAM-write signals of the packet
// receiver; master = control sequencer / front end, slave = receiver.
interface usb_rx_pkt_if #(
    parameter int RAM_AW = 12
);
    logic              fs;
    logic              fd;
    logic [RAM_AW-1:0] ram_init;
    logic [7:0]        rxd;
    logic              rxd_vld;
    logic [3:0]        btype;
    logic [15:0]       len;
    logic [31:0]       stat;
    logic [1:0]        err;
    logic [RAM_AW-1:0] ram_txa;
    logic [7:0]        ram_txd;
    logic              ram_txen;

    modport master (
        output fs, ram_init, rxd, rxd_vld,
        input  fd, btype, len, stat, err, ram_txa, ram_txd, ram_txen
    );

    modport slave (
        input  fs, ram_init, rxd, rxd_vld,
        output fd, btype, len, stat, err, ram_txa, ram_txd, ram_txen
    );
endinterface

// File: rtl/usb_rx_tmo.sv
// Idle timer: reloads to TIMEOUT on every received byte and counts down;
// expired is high once TIMEOUT byte-free cycles have elapsed.
module usb_rx_tmo #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CW'(TIMEOUT);
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expired = (cnt == '0);
endmodule

// File: rtl/usb_rx_pkt.sv
// Packet receiver: sync hunt, header parse, payload write to RAM, fs/fd report.
// Optional trailing checksum byte enabled by defining USB_RX_PKT_CSUM_EN.
//
// state | meaning
// IDLE  | waiting for fs rising; outputs hold last result
// HUNT  | looking for first sync byte 0x55, no timeout
// SYNC1 | 0x55 seen, expecting 0xAA
// TYPE  | expecting type byte (tag 0xA in upper nibble)
// LENH  | expecting length high byte
// LENL  | expecting length low byte, range checked here
// DATA  | payload bytes written to RAM
// CSUM  | expecting checksum byte (checksum build only)
// DONE  | fd high until fs falls
module usb_rx_pkt
    import usb_pkg::*;
#(
    parameter int RAM_AW  = 12,
    parameter int MAX_LEN = 1024,
    parameter int TIMEOUT = 255
) (
    input logic         clk,
    input logic         rst,
    usb_rx_pkt_if.slave bus
);
    state_t            state;
    logic [RAM_AW-1:0] base;
    logic [15:0]       idx;
    logic              fd_q;
    logic [3:0]        btype_q;
    logic [15:0]       len_q;
    logic [31:0]       stat_q;
    err_t              err_q;
    logic [RAM_AW-1:0] txa_q;
    logic [7:0]        txd_q;
    logic              txen_q;
    logic              tmo_exp;
    logic [15:0]       len_full;
    logic              last_byte;

    usb_rx_tmo #(.TIMEOUT(TIMEOUT)) u_tmo (
        .clk     (clk),
        .rst     (rst),
        .load    (bus.rxd_vld),
        .expired (tmo_exp)
    );

    assign len_full  = {len_q[15:8], bus.rxd};
    assign last_byte = (idx == len_q - 16'd1);

`ifdef USB_RX_PKT_CSUM_EN
    logic [7:0] csum_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            csum_q <= '0;
        end else if (bus.rxd_vld && bus.fs) begin
            case (state)
                ST_TYPE:                   csum_q <= bus.rxd;
                ST_LENH, ST_LENL, ST_DATA: csum_q <= csum_q ^ bus.rxd;
                default:                   ;
            endcase
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            base    <= '0;
            idx     <= '0;
            fd_q    <= 1'b0;
            btype_q <= '0;
            len_q   <= '0;
            stat_q  <= '0;
            err_q   <= ERR_OK;
            txa_q   <= '0;
            txd_q   <= '0;
            txen_q  <= 1'b0;
        end else begin
            txen_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.fs && !fd_q) begin
                        base   <= bus.ram_init;
                        err_q  <= ERR_OK;
                        stat_q <= '0;
                        idx    <= '0;
                        state  <= ST_HUNT;
                    end
                end
                ST_DONE: begin
                    if (!bus.fs) begin
                        fd_q  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    // fs dropped mid-packet: abandon quietly, keep results as they are
                    if (!bus.fs) begin
                        state <= ST_IDLE;
                    end else if (bus.rxd_vld) begin
                        case (state)
                            ST_HUNT: begin
                                if (bus.rxd == SYNC_0) state <= ST_SYNC1;
                            end
                            ST_SYNC1: begin
                                if (bus.rxd == SYNC_1)      state <= ST_TYPE;
                                else if (bus.rxd != SYNC_0) state <= ST_HUNT;
                            end
                            ST_TYPE: begin
                                if (bus.rxd[7:4] != TYPE_TAG) begin
                                    state <= ST_HUNT;
                                end else begin
                                    btype_q <= bus.rxd[3:0];
                                    state   <= ST_LENH;
                                end
                            end
                            ST_LENH: begin
                                len_q[15:8] <= bus.rxd;
                                state       <= ST_LENL;
                            end
                            ST_LENL: begin
                                len_q[7:0] <= bus.rxd;
                                if (!len_ok(len_full, MAX_LEN)) begin
                                    err_q <= ERR_LEN;
                                    fd_q  <= 1'b1;
                                    state <= ST_DONE;
                                end else begin
                                    idx   <= '0;
                                    state <= ST_DATA;
                                end
                            end
                            ST_DATA: begin
                                txen_q <= 1'b1;
                                txa_q  <= base + RAM_AW'(idx);
                                txd_q  <= bus.rxd;
                                if (idx < 16'd4) stat_q[{~idx[1:0], 3'b000} +: 8] <= bus.rxd;
                                idx <= idx + 16'd1;
                                if (last_byte) begin
`ifdef USB_RX_PKT_CSUM_EN
                                    state <= ST_CSUM;
`else
                                    fd_q  <= 1'b1;
                                    state <= ST_DONE;
`endif
                                end
                            end
`ifdef USB_RX_PKT_CSUM_EN
                            ST_CSUM: begin
                                err_q <= (bus.rxd == csum_q) ? ERR_OK : ERR_CSUM;
                                fd_q  <= 1'b1;
                                state <= ST_DONE;
                            end
`endif
                            default: state <= ST_IDLE;
                        endcase
                    end else if (tmo_exp && state != ST_HUNT) begin
                        err_q <= ERR_TMO;
                        fd_q  <= 1'b1;
                        state <= ST_DONE;
                    end
                end
            endcase
        end
    end

    assign bus.fd       = fd_q;
    assign bus.btype    = btype_q;
    assign bus.len      = len_q;
    assign bus.stat     = stat_q;
    assign bus.err      = err_q;
    assign bus.ram_txa  = txa_q;
    assign bus.ram_txd  = txd_q;
    assign bus.ram_txen = txen_q;
endmodule

// File: doc/usb_rx_pkt.md
# usb_rx_pkt

Parametrised packet receiver; next generation of the USB receive path. Consumes the recovered byte stream from the nibble-to-byte front end, hunts a two-byte sync, parses type and 16-bit length, writes the payload into the data RAM from a caller-supplied base address, and reports completion to the control sequencer over the fs/fd handshake. Adds length checking, idle timeout, error reporting and optional checksum, none of which the previous receiver had.

## Interface
- RAM_AW, 12, RAM address width
- MAX_LEN, 1024, largest legal payload length in bytes (1..65535)
- TIMEOUT, 255, idle cycles tolerated between bytes once sync is found (≥1)
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- fs  in  1  start: controller arms receiver, holds high until fd seen
- fd  out  1  done: high from completion until fs falls
- ram_init  in  RAM_AW  payload base address, sampled on fs rise
- rxd  in  8  received byte
- rxd_vld  in  1  rxd valid this cycle
- btype  out  4  packet type of last packet
- len  out  16  payload length of last packet
- stat  out  32  first four payload bytes, big-endian, zero-filled if shorter
- err  out  2  0 ok, 1 timeout, 2 bad length, 3 checksum
- ram_txa  out  RAM_AW  RAM write address
- ram_txd  out  8  RAM write data
- ram_txen  out  1  RAM write strobe

## Operation
- Frame: 0x55, 0xAA, TYPE, LEN_H, LEN_L, LEN payload bytes, [CSUM]. TYPE upper nibble must be 0xA, lower nibble is btype.
- States: IDLE, HUNT, SYNC1, TYPE, LENH, LENL, DATA, CSUM, DONE.
- IDLE: fs rising (fs=1, fd=0) → latch ram_init, clear err/stat/byte index → HUNT.
- HUNT: 0x55 → SYNC1; other bytes ignored; no timeout.
- SYNC1: 0xAA → TYPE; 0x55 stays SYNC1; else → HUNT.
- TYPE: upper nibble ≠ 0xA → HUNT; else latch btype → LENH → LENL.
- LENL: LEN = 0 or > MAX_LEN → err=2, DONE; else → DATA.
- DATA: each byte written to ram_init + index (mod 2^RAM_AW); bytes 0..3 shifted into stat; after LEN bytes → CSUM (macro on) or DONE.
- DONE: fd=1; fs low → fd=0 → IDLE.
- Timeout: idle counter reset on every rxd_vld; in SYNC1..CSUM, counter reaching TIMEOUT → err=1, DONE. Payload already written stays written.
- fs low in any state other than IDLE/DONE: abort to IDLE, fd never asserted, outputs hold.
- rxd_vld ignored in IDLE and DONE.

## Timing
- Reset: fd=0, btype=0, len=0, stat=0, err=0, ram_txa=0, ram_txd=0, ram_txen=0; state IDLE.
- ram_txen/ram_txa/ram_txd registered: byte accepted at cycle n → write visible at n+1, one cycle strobe.
- Back-to-back rxd_vld every cycle supported; no back-pressure.
- fd rises the cycle after the final byte (last payload or CSUM, or error detection) is accepted; last RAM write and fd coincide.
- btype, len, stat, err stable while fd=1.
- fs falling while fd=1: fd=0 next cycle.

## Configuration
- USB_RX_PKT_CSUM_EN defined: CSUM byte expected after payload; CSUM = XOR of TYPE, LEN_H, LEN_L and all payload bytes; mismatch → err=3 (payload still written). Timeout applies in CSUM.
- Undefined: no CSUM state; DONE directly after last payload byte; err=3 never produced.

## Structure
- Shared package usb_pkg: sync bytes 0x55/0xAA, type tag 0xA, err codes, state enum.
- One sub-module natural: usb_rx_tmo (loadable idle counter with expiry flag, parametrised by TIMEOUT).

## Test plan
- fs=1, ram_init=0x100, frame 55 AA A3 00 06 11 22 33 44 55 66 → six writes 0x100..0x105, btype=3, len=6, stat=0x11223344, err=0, fd=1.
- Garbage 00 55 55 AA A1 00 02 AB CD → sync found after repeated 55; writes at base, stat=0xABCD0000.
- ram_init=0xFFE, LEN=4 → addresses 0xFFE, 0xFFF, 0x000, 0x001.
- LEN=0x0401 with MAX_LEN=1024 → no writes, err=2, fd=1.
- Stream stops after 2 payload bytes, TIMEOUT=255 → err=1, fd 256 cycles after last byte, 2 writes kept.
- Macro on: correct CSUM → err=0; corrupted CSUM → err=3; fs dropped mid-payload → IDLE, fd stays 0.
